// File: rtl/sbus_ram_slave.sv
// Word-organised RAM responder for the simple bus (sbus), with programmable wait states and a stall handshake.
// Misaligned and out-of-range requests complete with error=1 and rdata=0. Their timing matches a normal access.
module sbus_ram_slave #(
    parameter int unsigned DEPTH   = 4096,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] BASE    = 32'h1FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  wen,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        error
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wen_q;
    logic [31:0] offset;
    logic        fault;
    logic        latch;
    logic        do_access;
    logic [31:0] mem [DEPTH];

    // Fault checks use the latched address. An address below BASE wraps when subtracted, so it needs its own test.
    assign offset = addr_q - BASE;
    assign fault  = (addr_q[1:0] != 2'b00) || (addr_q < BASE) || ((offset >> 2) >= DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 4'(LATENCY);
                end
            end
            WAIT: begin
                if (!en) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        stall     = en && (state != RESP);
        latch     = (state == IDLE) && en;
        do_access = (state == WAIT) && en && (cnt == 4'd0);
    end

    // Request fields are frozen at the IDLE->WAIT edge, so later changes on the bus do not affect this transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 4'h0;
            rdata   <= 32'h0;
            error   <= 1'b0;
        end else begin
            if (latch) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                wen_q   <= wen;
            end
            if (do_access) begin
                error <= fault;
                if (fault) begin
                    rdata <= 32'h0;
                end else if (wen_q == 4'h0) begin
                    rdata <= mem[offset[AW+1:2]];
                end
            end else if (state == RESP) begin
                error <= 1'b0;
            end
        end
    end

    // The RAM array has no reset, so that the block can map onto plain memory macros.
    always_ff @(posedge clk) begin
        if (do_access && !fault && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (wen_q[i]) begin
                    mem[offset[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_sbus_ram_slave.sv
// Directed bench for sbus_ram_slave. It drives one instance with LATENCY=2 and one with LATENCY=0 from a shared clock.
// Stimulus changes on falling edges, so the bench samples outputs halfway between active edges.
module tb_sbus_ram_slave;
    localparam logic [31:0] BASE  = 32'h1FC0_0000;
    localparam int unsigned DEPTH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_s, en_f;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_s, rdata_f;
    logic        stall_s, stall_f, error_s, error_f;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        err;
    int          ncyc;

    sbus_ram_slave #(.DEPTH(DEPTH), .LATENCY(2), .BASE(BASE)) dut_slow (
        .clk(clk), .rst(rst), .en(en_s), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata_s), .stall(stall_s), .error(error_s)
    );

    sbus_ram_slave #(.DEPTH(DEPTH), .LATENCY(0), .BASE(BASE)) dut_fast (
        .clk(clk), .rst(rst), .en(en_f), .wen(wen), .addr(addr), .wdata(wdata),
        .rdata(rdata_f), .stall(stall_f), .error(error_f)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Starts at a falling edge and returns at the falling edge inside the response cycle.
    // n counts the stalled cycles after the request is latched. Unless hold is set, the task also runs one idle cycle.
    task automatic applyStimulus(input bit fast, input logic [3:0] w, input logic [31:0] a,
                                 input logic [31:0] d, input bit hold, input bit from_resp,
                                 output logic [31:0] rdo, output logic erro, output int n);
        if (fast) en_f = 1'b1; else en_s = 1'b1;
        wen   = w;
        addr  = a;
        wdata = d;
        if (from_resp) begin
            @(negedge clk);
            checkOutput("bubble_stall", {31'b0, fast ? stall_f : stall_s}, 32'd1);
        end
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((fast ? stall_f : stall_s) == 1'b0) break;
            n++;
        end
        rdo  = fast ? rdata_f : rdata_s;
        erro = fast ? error_f : error_s;
        if (!hold) begin
            if (fast) en_f = 1'b0; else en_s = 1'b0;
            @(negedge clk);
            checkOutput("error_clear", {31'b0, fast ? error_f : error_s}, 32'd0);
        end
    endtask

    task automatic runXfer(input string tag, input bit fast, input logic [3:0] w,
                           input logic [31:0] a, input logic [31:0] d, input int exp_n,
                           input logic exp_err, input bit chk_rd, input logic [31:0] exp_rd);
        logic [31:0] r;
        logic        e;
        int          n;
        applyStimulus(fast, w, a, d, 1'b0, 1'b0, r, e, n);
        checkOutput({tag, "_cycles"}, n, exp_n);
        checkOutput({tag, "_error"}, {31'b0, e}, {31'b0, exp_err});
        if (chk_rd) checkOutput({tag, "_rdata"}, r, exp_rd);
    endtask

    initial begin
        rst = 1'b1; en_s = 1'b0; en_f = 1'b0;
        wen = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state and stall following en while reset is held
        @(negedge clk);
        checkOutput("rst_stall", {31'b0, stall_s}, 32'd0);
        checkOutput("rst_rdata", rdata_s, 32'h0);
        checkOutput("rst_error", {31'b0, error_s}, 32'd0);
        checkOutput("rst_rdata_fast", rdata_f, 32'h0);
        en_s = 1'b1;
        #1 checkOutput("rst_stall_en", {31'b0, stall_s}, 32'd1);
        en_s = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full write then read back
        runXfer("wr_full", 1'b0, 4'hF, BASE + 32'd8, 32'hDEADBEEF, 3, 1'b0, 1'b0, 32'h0);
        runXfer("rd_full", 1'b0, 4'h0, BASE + 32'd8, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);

        // Byte-strobed write merges with the existing word
        runXfer("pre4", 1'b0, 4'hF, BASE + 32'd4, 32'h11223344, 3, 1'b0, 1'b0, 32'h0);
        runXfer("wr_part", 1'b0, 4'b0101, BASE + 32'd4, 32'hAABBCCDD, 3, 1'b0, 1'b0, 32'h0);
        runXfer("rd_part", 1'b0, 4'h0, BASE + 32'd4, 32'h0, 3, 1'b0, 1'b1, 32'h11BB33DD);

        // Faulting requests neither write nor return data
        runXfer("pre0", 1'b0, 4'hF, BASE, 32'hCAFEF00D, 3, 1'b0, 1'b0, 32'h0);
        runXfer("rd0", 1'b0, 4'h0, BASE, 32'h0, 3, 1'b0, 1'b1, 32'hCAFEF00D);
        runXfer("misalign", 1'b0, 4'hF, BASE + 32'd2, 32'h12345678, 3, 1'b1, 1'b1, 32'h0);
        runXfer("rd_ok", 1'b0, 4'h0, BASE + 32'd8, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);
        runXfer("oor_hi", 1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h55555555, 3, 1'b1, 1'b1, 32'h0);
        runXfer("rd_ok2", 1'b0, 4'h0, BASE + 32'd4, 32'h0, 3, 1'b0, 1'b1, 32'h11BB33DD);
        runXfer("oor_lo", 1'b0, 4'h0, BASE - 32'd4, 32'h0, 3, 1'b1, 1'b1, 32'h0);
        runXfer("rd0_after", 1'b0, 4'h0, BASE, 32'h0, 3, 1'b0, 1'b1, 32'hCAFEF00D);

        // Abort: en drops during the second WAIT cycle of a write
        en_s = 1'b1; wen = 4'hF; addr = BASE + 32'd8; wdata = 32'h0BADF00D;
        @(negedge clk);
        @(negedge clk);
        en_s = 1'b0;
        #1 checkOutput("abort_stall", {31'b0, stall_s}, 32'd0);
        @(negedge clk);
        checkOutput("abort_error", {31'b0, error_s}, 32'd0);
        @(negedge clk);
        runXfer("abort_rd", 1'b0, 4'h0, BASE + 32'd8, 32'h0, 3, 1'b0, 1'b1, 32'hDEADBEEF);

        // Reset during WAIT of a write drops it
        runXfer("pre12", 1'b0, 4'hF, BASE + 32'd12, 32'h01020304, 3, 1'b0, 1'b0, 32'h0);
        en_s = 1'b1; wen = 4'hF; addr = BASE + 32'd12; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_stall", {31'b0, stall_s}, 32'd1);
        checkOutput("midrst_rdata", rdata_s, 32'h0);
        checkOutput("midrst_error", {31'b0, error_s}, 32'd0);
        en_s = 1'b0;
        #1 checkOutput("midrst_stall_low", {31'b0, stall_s}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        runXfer("midrst_rd", 1'b0, 4'h0, BASE + 32'd12, 32'h0, 3, 1'b0, 1'b1, 32'h01020304);
        runXfer("reissue_wr", 1'b0, 4'hF, BASE + 32'd12, 32'hFFFFFFFF, 3, 1'b0, 1'b0, 32'h0);
        runXfer("reissue_rd", 1'b0, 4'h0, BASE + 32'd12, 32'h0, 3, 1'b0, 1'b1, 32'hFFFFFFFF);

        // LATENCY=0 instance: preload, then back-to-back reads with en held
        runXfer("f_pre0", 1'b1, 4'hF, BASE, 32'hA5A5A5A5, 1, 1'b0, 1'b0, 32'h0);
        runXfer("f_pre4", 1'b1, 4'hF, BASE + 32'd4, 32'h5A5A5A5A, 1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 4'h0, BASE, 32'h0, 1'b1, 1'b0, rd, err, ncyc);
        checkOutput("f_b2b0_cycles", ncyc, 1);
        checkOutput("f_b2b0_rdata", rd, 32'hA5A5A5A5);
        checkOutput("f_b2b0_error", {31'b0, err}, 32'd0);
        applyStimulus(1'b1, 4'h0, BASE + 32'd4, 32'h0, 1'b0, 1'b1, rd, err, ncyc);
        checkOutput("f_b2b1_cycles", ncyc, 1);
        checkOutput("f_b2b1_rdata", rd, 32'h5A5A5A5A);
        checkOutput("f_b2b1_error", {31'b0, err}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
